// File: rtl/bcd_display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner_if
// Purpose  : Load handshake and display-bus bundle between the value producer
//            (master) and the BCD display scanner (slave).
// Revision : 1.0  initial release
// ============================================================================
interface bcd_display_scanner_if;
   logic        load;
   logic [15:0] value;
   logic        enable;
   logic        blank_lz;
   logic        busy;
   logic        done;
   logic [19:0] bcd;
   logic [3:0]  digit;
   logic [4:0]  digit_sel;

   modport master (
      output load, value, enable, blank_lz,
      input  busy, done, bcd, digit, digit_sel
   );

   modport slave (
      input  load, value, enable, blank_lz,
      output busy, done, bcd, digit, digit_sel
   );
endinterface
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner
// Purpose  : Converts a 16-bit binary value to five BCD digits (double dabble,
//            one iteration per cycle) and time-multiplexes the held result onto
//            a shared 4-bit digit bus with a one-hot digit select.
// Revision : 1.0  initial release
// ============================================================================
module bcd_display_scanner #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bcd_display_scanner_if.slave  bus
);

   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_CONVERT = 2'd1;
   localparam logic [1:0]  S_DONE    = 2'd2;

   localparam logic [4:0]  c_ITER_LAST = 5'd16;
   localparam logic [15:0] c_DIV_LAST  = 16'(SCAN_DIV - 1);
   localparam logic [2:0]  c_IDX_LAST  = 3'd4;

   logic [1:0]  r_state;
   logic [35:0] r_shift;
   logic [4:0]  r_iter;
   logic [19:0] r_bcd;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_div;
   logic [2:0]  r_idx;

   logic [35:0] w_adj;
   logic [35:0] w_shifted;
   logic [3:0]  w_nib;
   logic        w_upper_zero;

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
   always_comb begin
      w_adj = r_shift;
      for (int k = 0; k < 5; k++) begin
         if (r_shift[16 + 4*k +: 4] >= 4'd5) begin
            w_adj[16 + 4*k +: 4] = r_shift[16 + 4*k +: 4] + 4'd3;
         end
      end
      w_shifted = w_adj << 1;
   end

   // Conversion FSM; bcd is only written on entry to DONE so partial results never show.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_iter  <= '0;
         r_bcd   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.load) begin
                  r_shift <= {20'b0, bus.value};
                  r_iter  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CONVERT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CONVERT: begin
               if (r_iter == c_ITER_LAST) begin
                  r_bcd   <= r_shift[35:16];
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_shift <= w_shifted;
                  r_iter  <= r_iter + 5'd1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Free-running scan divider and digit index, independent of conversions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (r_div == c_DIV_LAST) begin
         r_div <= '0;
         r_idx <= (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
         r_div <= r_div + 16'd1;
      end
   end

   // Select the current nibble and whether it and every higher digit are zero.
   always_comb begin
      w_nib        = 4'hF;
      w_upper_zero = 1'b0;
      case (r_idx)
         3'd0: begin
            w_nib        = r_bcd[3:0];
            w_upper_zero = 1'b0;      // units digit is never blanked
         end
         3'd1: begin
            w_nib        = r_bcd[7:4];
            w_upper_zero = (r_bcd[19:4] == 16'd0);
         end
         3'd2: begin
            w_nib        = r_bcd[11:8];
            w_upper_zero = (r_bcd[19:8] == 12'd0);
         end
         3'd3: begin
            w_nib        = r_bcd[15:12];
            w_upper_zero = (r_bcd[19:12] == 8'd0);
         end
         3'd4: begin
            w_nib        = r_bcd[19:16];
            w_upper_zero = (r_bcd[19:16] == 4'd0);
         end
         default: begin
            w_nib        = 4'hF;
            w_upper_zero = 1'b0;
         end
      endcase
   end

   assign bus.digit     = !bus.enable                  ? 4'hF :
                          (bus.blank_lz && w_upper_zero) ? 4'hF : w_nib;
   assign bus.digit_sel = 5'd1 << r_idx;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.bcd       = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_scanner
// Purpose  : Self-checking bench for bcd_display_scanner against a decimal
//            arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_display_scanner;

   localparam int c_DIV = 4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   cyc;       // rising edges since reset release
   int   cur_val;   // value the display is expected to hold
   int   wait_n;
   int   pulses;

   bcd_display_scanner_if bus ();

   bcd_display_scanner #(.SCAN_DIV(c_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to predict the scan position.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < 5; k++) begin
         r[4*k +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [3:0] exp_digit(input int v, input int idx,
                                            input logic en, input logic blz);
      int p;
      p = 1;
      for (int k = 0; k < idx; k++) p = p * 10;
      if (!en) return 4'hF;
      if (blz && idx >= 1 && v < p) return 4'hF;
      return 4'((v / p) % 10);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks select and digit for n cycles; called at a falling edge.
   task automatic scan_check(input int n, input string tag);
      int idx;
      for (int i = 0; i < n; i++) begin
         idx = (cyc / c_DIV) % 5;
         chk({tag, "_sel"}, 32'(bus.digit_sel), 32'(1 << idx));
         chk({tag, "_digit"}, 32'(bus.digit),
             32'(exp_digit(cur_val, idx, bus.enable, bus.blank_lz)));
         @(negedge clk);
      end
   endtask

   // Load is already high at this falling edge; follows the conversion to its done cycle.
   task automatic finish_conv(input int v);
      logic ok;
      @(negedge clk);
      bus.load = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      chk("busy_window", 32'(ok), 32'd1);
      chk("done_pulse", 32'(bus.done), 32'd1);
      chk("busy_at_done", 32'(bus.busy), 32'd0);
      chk("bcd_result", 32'(bus.bcd), 32'(to_bcd(v)));
      cur_val = v;
   endtask

   task automatic convert(input int v);
      bus.load  = 1'b1;
      bus.value = 16'(v);
      finish_conv(v);
      @(negedge clk);
      chk("done_once", 32'(bus.done), 32'd0);
   endtask

   initial begin
      total = 0; bad = 0; cur_val = 0;
      rst_n = 1'b0;
      bus.load = 1'b0; bus.value = '0; bus.enable = 1'b1; bus.blank_lz = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_bcd", 32'(bus.bcd), 32'd0);
      chk("rst_sel", 32'(bus.digit_sel), 32'd1);
      chk("rst_digit_en", 32'(bus.digit), 32'h0);
      bus.enable = 1'b0;
      #1 chk("rst_digit_dis", 32'(bus.digit), 32'hF);
      bus.enable = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      scan_check(20, "idle_scan");
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Directed conversions
      convert(12345);
      scan_check(25, "scan12345");
      bus.enable = 1'b0;
      @(negedge clk);
      scan_check(10, "scan_disabled");
      bus.enable = 1'b1;
      convert(65535);
      convert(0);

      // Second load during conversion is ignored; then a load in the DONE cycle
      bus.load = 1'b1; bus.value = 16'd100;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (4) @(negedge clk);
      bus.load = 1'b1; bus.value = 16'd999;
      @(negedge clk);
      bus.load = 1'b0;
      wait_n = 0;
      while (bus.done !== 1'b1 && wait_n < 40) begin
         @(negedge clk);
         wait_n++;
      end
      chk("ignored_done_lat", 32'(wait_n), 32'd12);
      chk("ignored_bcd", 32'(bus.bcd), 32'h00100);
      cur_val = 100;
      bus.load = 1'b1; bus.value = 16'd7;
      finish_conv(7);
      @(negedge clk);

      // Leading-zero blanking
      bus.blank_lz = 1'b1;
      convert(42);
      scan_check(20, "blank42");
      convert(0);
      scan_check(20, "blank0");
      convert(10005);
      scan_check(20, "blank10005");

      // Randomized values and display controls
      for (int t = 0; t < 6; t++) begin
         convert(int'($urandom_range(0, 65535)));
         for (int j = 0; j < 15; j++) begin
            bus.enable   = 1'($urandom);
            bus.blank_lz = 1'($urandom);
            #1 scan_check(1, "rand");
         end
      end
      bus.enable = 1'b1; bus.blank_lz = 1'b0;

      // Reset in the middle of a conversion
      bus.load = 1'b1; bus.value = 16'd54321;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_bcd", 32'(bus.bcd), 32'd0);
      cur_val = 0;
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);
      scan_check(10, "post_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
